// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO built around a register-file storage block.
// Optional sticky overflow/underflow error flags are enabled with `define FIFO_CTRL_ERR_FLAGS_EN.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = 3,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam logic [ADDR_WIDTH:0] AF_THR = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_THR = AE_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q,  full_d;
    logic                  empty_q, empty_d;

    logic                  push_ok;
    logic                  pop_ok;
    logic [ADDR_WIDTH-1:0] w_ptr_inc;
    logic [ADDR_WIDTH-1:0] r_ptr_inc;

    // A push into a full FIFO is still accepted when a pop frees the head slot
    // at the same edge; the write lands on the slot being read.
    assign push_ok   = wr & (~full_q | rd);
    assign pop_ok    = rd & ~empty_q;
    assign w_ptr_inc = w_ptr_q + 1'b1;
    assign r_ptr_inc = r_ptr_q + 1'b1;

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        full_d  = full_q;
        empty_d = empty_q;

        if (push_ok) begin
            w_ptr_d = w_ptr_inc;
        end
        if (pop_ok) begin
            r_ptr_d = r_ptr_inc;
        end

        // Simultaneous push and pop leaves occupancy and both flags untouched.
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
            empty_d = 1'b0;
            full_d  = (w_ptr_inc == r_ptr_q);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
            full_d  = 1'b0;
            empty_d = (r_ptr_inc == w_ptr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    // A new error event in the clearing cycle takes priority over err_clr.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr && full_q && !rd) begin
            overflow_d = 1'b1;
        end
        if (rd && empty_q) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign wr_en        = push_ok;
    assign w_addr       = w_ptr_q;
    assign r_addr       = r_ptr_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_THR);
    assign almost_empty = (count_q <= AE_THR);

endmodule
